sm_trace_buf: RTL and testbench

- Synthesizable on-chip instruction trace recorder for the sm_cpu core.
- Captures {pc, instr} per enabled cycle into a circular buffer and stops a programmable number of samples after a PC-match trigger.
- A cycle watchdog ends capture on timeout.
- Sits beside sm_cpu on the board top. Gives FPGA builds the post-mortem trace and timeout detection the simulation bench provides.

---
 rtl/sm_trace_buf_pkg.sv | 11 +
 rtl/sm_trace_ram.sv | 25 ++
 rtl/sm_trace_buf.sv | 106 ++++++++++
 tb/tb_sm_trace_buf.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sm_trace_buf_pkg.sv
// sm_trace_buf_pkg: state encoding and default sizing shared by the trace buffer files
package sm_trace_buf_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_TIMEOUT = 120;
endpackage

// File: rtl/sm_trace_ram.sv
// sm_trace_ram: simple dual-port RAM, synchronous write, registered read (old data on collision)
module sm_trace_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;
  assign rdata_o = rdata_q;
  // write port, no reset so the array maps onto RAM primitives
  always_ff @(posedge clk)
    if (we_i) mem[waddr_i] <= wdata_i;
  // read register, clears on reset so the read outputs start at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else rdata_q <= mem[raddr_i];
endmodule

// File: rtl/sm_trace_buf.sv
// sm_trace_buf: circular {pc, instr} trace recorder with PC trigger, post-trigger window and watchdog
module sm_trace_buf
  import sm_trace_buf_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AW        = 4,
  parameter int DW        = 32,
  parameter int POST_TRIG = 4,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          en,
  input  logic [DW-1:0] pc,
  input  logic [31:0]   instr,
  input  logic          trig_en,
  input  logic [DW-1:0] trig_pc,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_pc,
  output logic [31:0]   rd_instr,
  output logic [AW:0]   count,
  output logic          armed,
  output logic          triggered,
  output logic          done,
  output logic          timeout,
  output logic [31:0]   cycle
);
  state_e        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] post_cnt_q;
  logic [AW:0]   post_cnt_d;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic [31:0]   cycle_q;
  logic [31:0]   cycle_d;
  logic          triggered_q;
  logic          timeout_q;
  logic          active;
  logic          cap;
  logic          trig_hit;
  logic          wd_hit;
  logic          post_last;
  logic [AW-1:0] rd_phys;

  assign active     = state_q == ST_ARMED || state_q == ST_POST;
  assign cap        = active && en && !arm;
  assign cycle_d    = cycle_q + 32'd1;
  assign count_d    = count_q == (AW+1)'(DEPTH) ? count_q : count_q + (AW+1)'(1);
  assign post_cnt_d = {1'b0, post_cnt_q} + (AW+1)'(1);
  assign trig_hit   = state_q == ST_ARMED && en && trig_en && pc == trig_pc;
  assign wd_hit     = TIMEOUT != 0 && active && cycle_d == 32'(TIMEOUT);
  assign post_last  = state_q == ST_POST && en && post_cnt_d == (AW+1)'(POST_TRIG);
  // oldest sample sits count entries behind the write pointer
  assign rd_phys    = wr_ptr_q - count_q[AW-1:0] + rd_addr;

  assign armed     = active;
  assign done      = state_q == ST_DONE;
  assign count     = count_q;
  assign triggered = triggered_q;
  assign timeout   = timeout_q;
  assign cycle     = cycle_q;

  // capture FSM: arm wins over everything, trigger and watchdog may both end capture in one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      cycle_q     <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else if (arm) begin
      state_q     <= ST_ARMED;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      cycle_q     <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else if (active) begin
      cycle_q <= cycle_d;
      if (en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        count_q  <= count_d;
      end
      if (trig_hit) begin
        triggered_q <= 1'b1;
        post_cnt_q  <= '0;
      end else if (state_q == ST_POST && en) post_cnt_q <= post_cnt_d[AW-1:0];
      if (wd_hit) timeout_q <= 1'b1;
      state_q <= wd_hit || post_last || (trig_hit && POST_TRIG == 0) ? ST_DONE :
                 trig_hit ? ST_POST : state_q;
    end

  sm_trace_ram #(.DEPTH(DEPTH), .AW(AW), .W(DW + 32)) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (cap),
    .waddr_i(wr_ptr_q),
    .wdata_i({pc, instr}),
    .raddr_i(rd_phys),
    .rdata_o({rd_pc, rd_instr})
  );
endmodule

// File: tb/tb_sm_trace_buf.sv
// tb_sm_trace_buf: two trace buffers (POST_TRIG 4 and 0) checked against a history-array model
module tb_sm_trace_buf;
  logic        clk = 0;
  logic        rst_n;
  logic        arm, en, trig_en;
  logic [31:0] pc, instr, trig_pc;
  logic [3:0]  rd_addr;
  logic [31:0] rd_pc_a [2];
  logic [31:0] rd_instr_a [2];
  logic [4:0]  count_a [2];
  logic        armed_a [2];
  logic        trig_a [2];
  logic        done_a [2];
  logic        to_a [2];
  logic [31:0] cycle_a [2];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sm_trace_buf #(.POST_TRIG(4)) u0 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .en(en), .pc(pc), .instr(instr),
    .trig_en(trig_en), .trig_pc(trig_pc), .rd_addr(rd_addr),
    .rd_pc(rd_pc_a[0]), .rd_instr(rd_instr_a[0]), .count(count_a[0]), .armed(armed_a[0]),
    .triggered(trig_a[0]), .done(done_a[0]), .timeout(to_a[0]), .cycle(cycle_a[0])
  );

  sm_trace_buf #(.POST_TRIG(0)) u1 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .en(en), .pc(pc), .instr(instr),
    .trig_en(trig_en), .trig_pc(trig_pc), .rd_addr(rd_addr),
    .rd_pc(rd_pc_a[1]), .rd_instr(rd_instr_a[1]), .count(count_a[1]), .armed(armed_a[1]),
    .triggered(trig_a[1]), .done(done_a[1]), .timeout(to_a[1]), .cycle(cycle_a[1])
  );

  // model: 0 idle, 1 capturing before trigger, 2 capturing after trigger, 3 stopped
  int          m_st [2];
  int          m_n [2];
  int          m_cyc [2];
  int          m_post [2];
  bit          m_trg [2];
  bit          m_to [2];
  bit          m_rv [2];
  logic [63:0] m_rd [2];
  logic [63:0] hist [2][128];
  int          mc;

  function automatic int stored(int n);
    return n < 16 ? n : 16;
  endfunction

  always @(posedge clk or negedge rst_n)
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_st[k] = 0; m_n[k] = 0; m_cyc[k] = 0; m_post[k] = 0;
        m_trg[k] = 0; m_to[k] = 0; m_rv[k] = 1; m_rd[k] = 0;
      end else begin
        mc = stored(m_n[k]);
        m_rv[k] = int'(rd_addr) < mc;
        if (m_rv[k]) m_rd[k] = hist[k][m_n[k] - mc + int'(rd_addr)];
        if (arm) begin
          m_st[k] = 1; m_n[k] = 0; m_cyc[k] = 0; m_post[k] = 0; m_trg[k] = 0; m_to[k] = 0;
        end else if (m_st[k] == 1 || m_st[k] == 2) begin
          m_cyc[k]++;
          if (en) begin
            if (m_n[k] < 128) hist[k][m_n[k]] = {pc, instr};
            m_n[k]++;
            if (m_st[k] == 1 && trig_en && pc == trig_pc) begin
              m_trg[k] = 1;
              m_post[k] = 0;
              m_st[k] = (k == 0) ? 2 : 3;
            end else if (m_st[k] == 2) begin
              m_post[k]++;
              if (m_post[k] == 4) m_st[k] = 3;
            end
          end
          if (m_cyc[k] == 120) begin
            m_to[k] = 1;
            m_st[k] = 3;
          end
        end
      end
    end

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h want %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      chk("count", k, 64'(count_a[k]), 64'(stored(m_n[k])));
      chk("armed", k, 64'(armed_a[k]), 64'(m_st[k] == 1 || m_st[k] == 2));
      chk("done", k, 64'(done_a[k]), 64'(m_st[k] == 3));
      chk("triggered", k, 64'(trig_a[k]), 64'(m_trg[k]));
      chk("timeout", k, 64'(to_a[k]), 64'(m_to[k]));
      chk("cycle", k, 64'(cycle_a[k]), 64'(m_cyc[k]));
      if (m_rv[k]) chk("rd", k, {rd_pc_a[k], rd_instr_a[k]}, m_rd[k]);
    end

  function automatic logic [31:0] mk_instr(input logic [31:0] p);
    return {~p[15:0], p[15:0]};
  endfunction

  task automatic arm_pulse();
    arm = 1; en = 1; pc = 32'hdead; instr = 0;
    @(negedge clk);
    arm = 0;
  endtask

  task automatic seq(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      pc = 32'(i); instr = mk_instr(32'(i)); en = gaps ? (i % 2 == 0) : 1'b1;
      @(negedge clk);
    end
    en = 0;
  endtask

  task automatic rd(input int a);
    rd_addr = 4'(a);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1; arm = 0; en = 0; trig_en = 0; pc = 0; instr = 0; trig_pc = 0; rd_addr = 0;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_count", 0, 64'(count_a[0]), 0);
    chk("rst_rdpc", 0, 64'(rd_pc_a[0]), 0);
    chk("rst_armed", 0, 64'(armed_a[0]), 0);
    rst_n = 1;
    // basic trigger at pc 10
    trig_en = 1; trig_pc = 10;
    arm_pulse();
    seq(25, 0);
    chk("t1_done", 0, 64'(done_a[0]), 1);
    chk("t1_count", 0, 64'(count_a[0]), 15);
    chk("t1_cycle", 0, 64'(cycle_a[0]), 15);
    chk("t1_count", 1, 64'(count_a[1]), 11);
    rd(0);
    chk("t1_rd0", 0, {rd_pc_a[0], rd_instr_a[0]}, {32'd0, 32'hffff0000});
    rd(14);
    chk("t1_rd14", 0, 64'(rd_pc_a[0]), 14);
    // wrap-around
    trig_pc = 30;
    arm_pulse();
    seq(40, 0);
    chk("t2_count", 0, 64'(count_a[0]), 16);
    rd(0);
    chk("t2_rd0", 0, 64'(rd_pc_a[0]), 19);
    chk("t2_rd0", 1, 64'(rd_pc_a[1]), 15);
    rd(15);
    chk("t2_rd15", 0, 64'(rd_pc_a[0]), 34);
    // watchdog
    trig_en = 0;
    arm_pulse();
    seq(130, 0);
    chk("t3_cycle", 0, 64'(cycle_a[0]), 120);
    chk("t3_timeout", 0, 64'(to_a[0]), 1);
    chk("t3_trig", 0, 64'(trig_a[0]), 0);
    rd(0);
    chk("t3_rd0", 0, 64'(rd_pc_a[0]), 104);
    // en gaps
    arm_pulse();
    seq(10, 1);
    chk("t4_count", 0, 64'(count_a[0]), 5);
    chk("t4_cycle", 0, 64'(cycle_a[0]), 10);
    rd(4);
    chk("t4_rd4", 0, 64'(rd_pc_a[0]), 8);
    // POST_TRIG=0 and re-arm
    trig_en = 1; trig_pc = 5;
    arm_pulse();
    seq(8, 0);
    chk("t5_done", 1, 64'(done_a[1]), 1);
    chk("t5_count", 1, 64'(count_a[1]), 6);
    chk("t5_cycle", 1, 64'(cycle_a[1]), 6);
    arm_pulse();
    chk("t5_rearm_count", 1, 64'(count_a[1]), 0);
    chk("t5_rearm_trig", 1, 64'(trig_a[1]), 0);
    chk("t5_rearm_cycle", 1, 64'(cycle_a[1]), 0);
    chk("t5_rearm_armed", 1, 64'(armed_a[1]), 1);
    // async reset in the middle of the post-trigger window
    trig_pc = 3;
    arm_pulse();
    seq(5, 0);
    #2 rst_n = 0;
    #1;
    chk("t6_count", 0, 64'(count_a[0]), 0);
    chk("t6_armed", 0, 64'(armed_a[0]), 0);
    chk("t6_trig", 0, 64'(trig_a[0]), 0);
    chk("t6_cycle", 0, 64'(cycle_a[0]), 0);
    chk("t6_rd", 0, {rd_pc_a[0], rd_instr_a[0]}, 0);
    @(negedge clk);
    rst_n = 1;
    seq(6, 0);
    chk("t6_idle_armed", 0, 64'(armed_a[0]), 0);
    chk("t6_idle_count", 0, 64'(count_a[0]), 0);
    chk("t6_idle_done", 0, 64'(done_a[0]), 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      arm = $urandom_range(0, 29) == 0;
      en = $urandom_range(0, 3) != 0;
      trig_en = $urandom_range(0, 1) == 1;
      pc = $urandom_range(0, 15);
      trig_pc = $urandom_range(0, 15);
      instr = $urandom;
      rd_addr = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
